if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Parametrised IF/ID pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush-to-bubble, and saturating stall/flush event counters. It sits between instruction fetch and decode and replaces the free-running PC/instruction latch. Decode can therefore back-pressure fetch without a combinational ready path, and the hazard unit can squash the stage on a taken branch.

## Interface
Parameters:
- PC_W, default 32: width of the program counter field.
- INST_W, default 32: width of the instruction field.
- NOP_INST, default 32'h00000013: bubble encoding driven on inst_o when the stage is empty or flushed. Width is INST_W.
- CNT_W, default 16: width of each event counter.

Ports:
- clk_i, input, 1: clock. All state changes on the rising edge.
- rst_n_i, input, 1: asynchronous, active-low reset.
- valid_i, input, 1: fetch presents a valid PC/instruction.
- ready_o, output, 1: stage can accept. Registered.
- PC_i, input, PC_W: fetched PC.
- inst_i, input, INST_W: fetched instruction.
- valid_o, output, 1: decode-side payload valid.
- ready_i, input, 1: decode accepts the payload this cycle.
- PC_o, output, PC_W: payload PC.
- inst_o, output, INST_W: payload instruction, or NOP_INST when the stage is not valid.
- flush_i, input, 1: squash all held and incoming entries.
- stall_cnt_o, output, CNT_W: cycles with valid_o=1 and ready_i=0. Saturating.
- flush_cnt_o, output, CNT_W: flushes that discarded at least one valid entry. Saturating.

## Operation
- Storage is a main register (drives the outputs) plus a skid register.
- Three states:
  - EMPTY: both registers invalid.
  - FULL: main valid, skid invalid.
  - SKID: both valid.
- Handshake events:
  - Upstream transfer (acc) = valid_i & ready_o.
  - Downstream transfer (pop) = valid_o & ready_i.
- ready_o = 1 in EMPTY and FULL, 0 in SKID. It is a pure function of registered state.
- Transitions when flush_i=0:
  - EMPTY, acc: main <= input; go to FULL. Otherwise stay EMPTY.
  - FULL, acc & pop: main <= input; stay FULL.
  - FULL, acc & !pop: skid <= input; go to SKID.
  - FULL, !acc & pop: go to EMPTY.
  - FULL, !acc & !pop: hold.
  - SKID, pop: main <= skid; go to FULL. No accept is possible because ready_o=0.
  - SKID, !pop: hold.
- Flush:
  - flush_i=1 overrides everything. Next state is EMPTY.
  - Main PC is cleared to 0 and main inst is set to NOP_INST.
  - Any acc in the same cycle is discarded. Fetch treats it as consumed and re-fetches from the redirect target.
  - A pop in the same cycle still counts as accepted by decode. Decode squashes it itself.
- Output rules:
  - valid_o = main valid.
  - When valid_o=0, inst_o = NOP_INST and PC_o = 0. Data registers are loaded with these values whenever main is invalidated.
- Order is preserved: the skid entry always leaves after the main entry, and none are dropped except by flush.
- Counters:
  - stall_cnt increments in any cycle with valid_o & !ready_i, including a cycle with flush_i=1.
  - flush_cnt increments on a flush_i=1 cycle when state ≠ EMPTY or valid_i=1.
  - Both saturate at 2^CNT_W−1. They clear only on reset.

## Timing
- Reset (asynchronous, while rst_n_i=0):
  - State EMPTY; valid_o=0; ready_o=1; PC_o=0; inst_o=NOP_INST.
  - stall_cnt_o=0; flush_cnt_o=0.
  - Skid register cleared.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency is one cycle: an entry accepted at edge n appears on valid_o/PC_o/inst_o after edge n.
- Throughput is one entry per cycle while ready_i=1. No bubble is inserted in steady-state streaming.
- Backpressure:
  - The cycle after the first ready_i=0 with valid_o=1, one extra entry may land in skid, and ready_o drops at that edge.
  - ready_o returns to 1 the edge after the first pop in SKID.
- There is no combinational path from ready_i or flush_i to ready_o or any data output. All outputs are flop outputs.
- Counters update on the same edge as the qualifying cycle and are visible the following cycle.

## Test plan
- Reset and idle: hold rst_n_i=0 for 3 cycles, then release with valid_i=0. Required: valid_o=0, ready_o=1, inst_o=0x00000013, PC_o=0, both counters 0.
- Streaming: present PC 0x00,0x04,0x08,0x0C back-to-back with ready_i=1. Required: the same sequence on PC_o one cycle later, valid_o continuous, ready_o held at 1, stall_cnt_o=0.
- Skid: stream 0x00,0x04,0x08 and drop ready_i for 3 cycles while 0x04 is in flight. Required:
  - 0x00 is held on PC_o.
  - 0x04 is captured in skid; ready_o=0 the next cycle; 0x08 is held upstream.
  - stall_cnt_o=3.
  - After release, output order is 0x00,0x04,0x08 with no loss or duplication.
- Flush in SKID: fill both entries, then assert flush_i with valid_i=1 (PC 0x40). Required:
  - The next cycle shows valid_o=0, inst_o=NOP_INST, ready_o=1, flush_cnt_o=1.
  - 0x40 never appears.
  - Flushing again while EMPTY with valid_i=0 leaves flush_cnt_o=1.
- Counter saturation: with CNT_W=4, hold valid_o=1 and ready_i=0 for 20 cycles. Required: stall_cnt_o stops at 15.
- Asynchronous reset mid-stall: assert rst_n_i between edges while in SKID. Required: outputs reach reset values before the next clock edge, and operation resumes normally after release.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID stage register: valid/ready handshake with a one-entry skid buffer,
// synchronous flush-to-bubble and saturating stall/flush event counters.
module if_id_skid_reg #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int                CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [PC_W-1:0]   PC_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PC_W-1:0]   PC_o,
    output logic [INST_W-1:0] inst_o,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    localparam entry_t           BUBBLE  = {{PC_W{1'b0}}, NOP_INST};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    entry_t           main_q, skid_q;
    logic             valid_q, ready_q;
    logic [CNT_W-1:0] stall_q, flush_q;

    entry_t in_e;
    logic   acc, pop;

    assign in_e = '{pc: PC_i, inst: inst_i};
    assign acc  = valid_i & ready_q;
    assign pop  = valid_q & ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (valid_q && !ready_i && stall_q != CNT_MAX)
                stall_q <= stall_q + CNT_W'(1);
            if (flush_i && (state_q != EMPTY || valid_i) && flush_q != CNT_MAX)
                flush_q <= flush_q + CNT_W'(1);

            // Flush wins over any same-cycle accept; the popped entry is squashed by decode.
            if (flush_i) begin
                state_q <= EMPTY;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
                main_q  <= BUBBLE;
                skid_q  <= BUBBLE;
            end else begin
                case (state_q)
                    EMPTY: if (acc) begin
                        main_q  <= in_e;
                        valid_q <= 1'b1;
                        state_q <= FULL;
                    end
                    FULL: begin
                        if (acc && pop) begin
                            main_q <= in_e;
                        end else if (acc) begin
                            skid_q  <= in_e;
                            ready_q <= 1'b0;
                            state_q <= SKID;
                        end else if (pop) begin
                            main_q  <= BUBBLE;
                            valid_q <= 1'b0;
                            state_q <= EMPTY;
                        end
                    end
                    SKID: if (pop) begin
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                        ready_q <= 1'b1;
                        state_q <= FULL;
                    end
                    default: begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        main_q  <= BUBBLE;
                        skid_q  <= BUBBLE;
                    end
                endcase
            end
        end
    end

    assign ready_o     = ready_q;
    assign valid_o     = valid_q;
    assign PC_o        = main_q.pc;
    assign inst_o      = main_q.inst;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: queue-based reference model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_if_id_skid_reg;

    localparam int PW = 32;
    localparam int IW = 32;
    localparam int CW = 4;
    localparam logic [IW-1:0] NOP = 32'h0000_0013;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i, ready_i, flush_i;
    logic [PW-1:0] PC_i;
    logic [IW-1:0] inst_i;
    logic          ready_o, valid_o;
    logic [PW-1:0] PC_o;
    logic [IW-1:0] inst_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int total = 0;
    int bad   = 0;

    if_id_skid_reg #(.PC_W(PW), .INST_W(IW), .NOP_INST(NOP), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .valid_i(valid_i), .ready_o(ready_o), .PC_i(PC_i), .inst_i(inst_i),
        .valid_o(valid_o), .ready_i(ready_i), .PC_o(PC_o), .inst_o(inst_o),
        .flush_i(flush_i), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk_inst(input logic [PW-1:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // Reference model: the stage is a FIFO of at most two entries.
    typedef struct { logic [PW-1:0] pc; logic [IW-1:0] inst; } ent_t;
    ent_t mq[$];
    int   m_stall = 0, m_flush = 0;
    bit   m_acc, m_pop;
    bit   seen40 = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_acc = valid_i && mq.size() < 2;
            m_pop = mq.size() > 0 && ready_i;
            if (mq.size() > 0 && !ready_i && m_stall < CMAX) m_stall++;
            if (flush_i) begin
                if ((mq.size() > 0 || valid_i) && m_flush < CMAX) m_flush++;
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) mq.push_back('{pc: PC_i, inst: inst_i});
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", valid_o, mq.size() > 0);
        chk("m_ready", ready_o, mq.size() < 2);
        chk("m_pc",    PC_o,    mq.size() > 0 ? mq[0].pc : '0);
        chk("m_inst",  inst_o,  mq.size() > 0 ? mq[0].inst : NOP);
        chk("m_stall", stall_cnt_o, m_stall);
        chk("m_flush", flush_cnt_o, m_flush);
        if (valid_o && PC_o == 32'h40) seen40 = 1;
    end

    // Apply inputs, let one rising edge consume them, return at negedge+1.
    task automatic tick(input logic v, input logic [PW-1:0] pc, input logic rdy, input logic fl);
        valid_i = v;
        PC_i    = pc;
        inst_i  = mk_inst(pc);
        ready_i = rdy;
        flush_i = fl;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid_i = 0; ready_i = 1; flush_i = 0; PC_i = '0; inst_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick(0, 0, 1, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_inst",  inst_o, 32'h13);
        chk("rst_pc",    PC_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_flush", flush_cnt_o, 0);

        // Streaming
        for (int i = 0; i < 4; i++) begin
            tick(1, PW'(i * 4), 1, 0);
            chk("str_pc", PC_o, i * 4);
            chk("str_valid", valid_o, 1);
            chk("str_ready", ready_o, 1);
        end
        tick(0, 0, 1, 0);
        chk("str_drain", valid_o, 0);
        chk("str_stall", stall_cnt_o, 0);

        // Skid: 0x04 lands in skid while decode stalls for three cycles
        tick(1, 32'h00, 1, 0);
        tick(1, 32'h04, 0, 0);
        chk("skid_ready", ready_o, 0);
        chk("skid_hold", PC_o, 32'h00);
        tick(1, 32'h08, 0, 0);
        tick(1, 32'h08, 0, 0);
        chk("skid_stall", stall_cnt_o, 3);
        chk("skid_hold2", PC_o, 32'h00);
        tick(1, 32'h08, 1, 0);
        chk("skid_o1", PC_o, 32'h04);
        chk("skid_rdy_back", ready_o, 1);
        tick(1, 32'h08, 1, 0);
        chk("skid_o2", PC_o, 32'h08);
        tick(0, 0, 1, 0);
        chk("skid_empty", valid_o, 0);

        // Flush while SKID with a fresh fetch present
        tick(1, 32'h10, 0, 0);
        tick(1, 32'h14, 0, 0);
        chk("fl_full", ready_o, 0);
        tick(1, 32'h40, 0, 1);
        chk("fl_valid", valid_o, 0);
        chk("fl_inst", inst_o, NOP);
        chk("fl_ready", ready_o, 1);
        chk("fl_cnt", flush_cnt_o, 1);
        chk("fl_stall", stall_cnt_o, 5);
        tick(0, 0, 1, 1);
        chk("fl_cnt_empty", flush_cnt_o, 1);
        tick(0, 0, 1, 0);
        chk("fl_no40", seen40, 0);

        // Counter saturation
        tick(1, 32'h20, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0);
        chk("sat_stall", stall_cnt_o, CMAX);
        chk("sat_pc", PC_o, 32'h20);

        // Asynchronous reset between edges while in SKID
        tick(1, 32'h24, 0, 0);
        chk("ar_skid", ready_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", valid_o, 0);
        chk("ar_ready", ready_o, 1);
        chk("ar_pc", PC_o, 0);
        chk("ar_inst", inst_o, NOP);
        chk("ar_stall", stall_cnt_o, 0);
        chk("ar_flush", flush_cnt_o, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick(1, 32'h30, 1, 0);
        chk("res_pc0", PC_o, 32'h30);
        tick(1, 32'h34, 1, 0);
        chk("res_pc1", PC_o, 32'h34);
        chk("res_inst1", inst_o, 32'hA000_0034);
        tick(0, 0, 1, 0);
        chk("res_empty", valid_o, 0);
        tick(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
